// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: bus word, FSM states, word geometry.
package imem_loader_pkg;
    typedef logic [31:0] DATA_BUS;

    localparam int WORD_BYTES = 4;

    typedef enum logic [2:0] {
        IDLE, HDR, DATA, WRITE, CSUM, DONE, ERR
    } LOADER_STATE;
endpackage

// File: rtl/imem_loader_if.sv
// Host byte channel plus instruction-memory write port of the loader.
interface imem_loader_if;
    logic                     byte_valid;
    logic [7:0]               byte_data;
    logic                     byte_ready;
    logic                     mem_we;
    imem_loader_pkg::DATA_BUS mem_addr;
    imem_loader_pkg::DATA_BUS mem_wdata;

    modport slave  (input  byte_valid, byte_data, output byte_ready, mem_we, mem_addr, mem_wdata);
    modport master (output byte_valid, byte_data, input  byte_ready, mem_we, mem_addr, mem_wdata);
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Little-endian byte-to-word shifter with byte counter and running XOR checksum.
module imem_loader_word_assembler
    import imem_loader_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       shift_en,
    input  logic       csum_en,
    input  logic [7:0] byte_in,
    output DATA_BUS    word_nxt,
    output logic       word_ready,
    output logic [7:0] csum
);
    logic [1:0] cnt;
    DATA_BUS    word_q;

    // Shift right so the first byte of a word ends up in bits 7:0.
    assign word_nxt   = {byte_in, word_q[31:8]};
    assign word_ready = shift_en && (cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt    <= '0;
            word_q <= '0;
            csum   <= '0;
        end else if (shift_en) begin
            cnt    <= cnt + 2'd1;
            word_q <= word_nxt;
            if (csum_en) csum <= csum ^ byte_in;
        end
    end
endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed, XOR-checksummed program image into instruction memory,
// holding the core in reset until the image is verified.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int      DEPTH_WORDS = 256,
    parameter DATA_BUS BASE_ADDR   = 32'h0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    imem_loader_if.slave    bus,
    output logic            cpu_rst,
    output logic            busy,
    output logic            done,
    output logic            error
);
    LOADER_STATE state, nxt;
    DATA_BUS     idx, len, word_nxt;
    logic [7:0]  csum;
    logic        xfer, word_ready, restart;

    assign bus.byte_ready = (state == HDR) || (state == DATA) || (state == CSUM);
    assign bus.mem_we     = (state == WRITE);
    assign xfer           = bus.byte_valid && bus.byte_ready;
    assign restart        = start && ((state == IDLE) || (state == DONE) || (state == ERR));

    assign cpu_rst = (state != DONE);
    assign busy    = (state == HDR) || (state == DATA) || (state == WRITE) || (state == CSUM);
    assign done    = (state == DONE);
    assign error   = (state == ERR);

    imem_loader_word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clear      (restart),
        .shift_en   (xfer && (state != CSUM)),
        .csum_en    (state == DATA),
        .byte_in    (bus.byte_data),
        .word_nxt   (word_nxt),
        .word_ready (word_ready),
        .csum       (csum)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  if (start) nxt = HDR;
            HDR:   if (word_ready) begin
                       if (word_nxt == '0)                         nxt = CSUM;
                       else if (word_nxt > DATA_BUS'(DEPTH_WORDS)) nxt = ERR;
                       else                                        nxt = DATA;
                   end
            DATA:  if (word_ready) nxt = WRITE;
            WRITE: nxt = (idx + 32'd1 == len) ? CSUM : DATA;
            CSUM:  if (xfer) nxt = (bus.byte_data == csum) ? DONE : ERR;
            DONE,
            ERR:   if (start) nxt = HDR;
            default: nxt = IDLE;
        endcase
    end

    // Address/data are captured on the last byte so the write lands one cycle later and then holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= '0;
            len           <= '0;
            bus.mem_addr  <= BASE_ADDR;
            bus.mem_wdata <= '0;
        end else begin
            if (restart) begin
                idx <= '0;
                len <= '0;
            end
            if (state == HDR && word_ready) len <= word_nxt;
            if (state == DATA && word_ready) begin
                bus.mem_addr  <= BASE_ADDR + (idx << 2);
                bus.mem_wdata <= word_nxt;
            end
            if (state == WRITE) idx <= idx + 32'd1;
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads, checksum errors, overflow, gaps, mid-session reset.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst, start;
    logic cpu_rst, busy, done, error;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_loader_if ifc ();

    imem_loader #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start), .bus(ifc.slave),
        .cpu_rst(cpu_rst), .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Record every write; a write cycle must never also accept a byte.
    always @(negedge clk) begin
        if (ifc.mem_we === 1'b1) begin
            wa.push_back(ifc.mem_addr);
            wd.push_back(ifc.mem_wdata);
            chk("ready_in_write", {31'b0, ifc.byte_ready}, 32'd0);
        end
    end

    // Present a byte (after optional idle gap) and return right after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap = 0);
        int n;
        repeat (gap) begin
            @(negedge clk);
            ifc.byte_valid = 1'b0;
        end
        @(negedge clk);
        ifc.byte_valid = 1'b1;
        ifc.byte_data  = b;
        n = 0;
        while (ifc.byte_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk("xfer_timeout", n, 0);
        @(posedge clk);
    endtask

    task automatic send_seq(input logic [7:0] bytes[], input int max_gap);
        foreach (bytes[i]) send_byte(bytes[i], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
        @(negedge clk);
        ifc.byte_valid = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        ifc.byte_valid = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        ifc.byte_valid = 1'b0;
        rst = 1'b1;
        repeat (cycles) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic chk_status(input string tag, input logic [3:0] exp);
        chk(tag, {28'b0, cpu_rst, busy, done, error}, {28'b0, exp});
    endtask

    // XOR of the eight data bytes 13 05 A0 00 93 05 10 00 is 0x30.
    logic [7:0] img_ok[]  = '{8'h02,8'h00,8'h00,8'h00, 8'h13,8'h05,8'hA0,8'h00, 8'h93,8'h05,8'h10,8'h00, 8'h30};
    logic [7:0] img_bad[] = '{8'h02,8'h00,8'h00,8'h00, 8'h13,8'h05,8'hA0,8'h00, 8'h93,8'h05,8'h10,8'h00, 8'h2C};
    logic [7:0] hdr_ovf[] = '{8'h01,8'h01,8'h00,8'h00};
    logic [7:0] hdr_max[] = '{8'h00,8'h01,8'h00,8'h00};
    logic [7:0] img_nul[] = '{8'h00,8'h00,8'h00,8'h00, 8'h00};
    logic [7:0] part_a[]  = '{8'h02,8'h00,8'h00,8'h00, 8'h13,8'h05,8'hA0,8'h00};
    logic [7:0] part_b[]  = '{8'h93,8'h05,8'h10,8'h00, 8'h30};
    logic [7:0] part_c[]  = '{8'h02,8'h00,8'h00,8'h00, 8'h13,8'h05,8'hA0,8'h00, 8'h93,8'h05};
    logic [7:0] img_one[] = '{8'h01,8'h00,8'h00,8'h00, 8'hEF,8'hBE,8'hAD,8'hDE, 8'h22};

    task automatic chk_two_writes(input string tag);
        chk({tag, "_cnt"}, wa.size(), 2);
        if (wa.size() == 2) begin
            chk({tag, "_a0"}, wa[0], 32'h0);
            chk({tag, "_d0"}, wd[0], 32'h00A00513);
            chk({tag, "_a1"}, wa[1], 32'h4);
            chk({tag, "_d1"}, wd[1], 32'h00100593);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timed out");
    end

    initial begin
        rst = 1'b1; start = 1'b0;
        ifc.byte_valid = 1'b0; ifc.byte_data = 8'h00;
        repeat (2) @(negedge clk);

        // Reset values, {cpu_rst,busy,done,error}
        chk_status("rst_status", 4'b1000);
        chk("rst_ready", {31'b0, ifc.byte_ready}, 0);
        chk("rst_we",    {31'b0, ifc.mem_we}, 0);
        chk("rst_addr",  ifc.mem_addr, 32'h0);
        chk("rst_wdata", ifc.mem_wdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk_status("idle_status", 4'b1000);

        // Good two-word load
        pulse_start();
        chk_status("hdr_status", 4'b1100);
        chk("hdr_ready", {31'b0, ifc.byte_ready}, 1);
        wa.delete(); wd.delete();
        send_seq(img_ok, 0);
        chk_status("ok_status", 4'b0010);
        chk_two_writes("ok");
        chk("ok_addr_hold", ifc.mem_addr, 32'h4);
        chk("ok_data_hold", ifc.mem_wdata, 32'h00100593);

        // Restart from DONE with a wrong checksum
        pulse_start();
        chk_status("restart_status", 4'b1100);
        wa.delete(); wd.delete();
        send_seq(img_bad, 0);
        chk_status("bad_status", 4'b1001);
        chk_two_writes("bad");

        // Overflow header N=257
        pulse_start();
        wa.delete(); wd.delete();
        send_seq(hdr_ovf, 0);
        repeat (3) @(negedge clk);
        chk_status("ovf_status", 4'b1001);
        chk("ovf_writes", wa.size(), 0);

        // N=256 is the largest legal length
        pulse_start();
        send_seq(hdr_max, 0);
        chk_status("max_status", 4'b1100);
        chk("max_ready", {31'b0, ifc.byte_ready}, 1);
        do_reset(1);
        chk_status("max_rst", 4'b1000);

        // Random gaps plus an ignored start while busy
        pulse_start();
        wa.delete(); wd.delete();
        send_seq(part_a, 3);
        pulse_start();
        chk_status("busy_start", 4'b1100);
        send_seq(part_b, 3);
        chk_status("gap_status", 4'b0010);
        chk_two_writes("gap");

        // Empty image
        pulse_start();
        wa.delete(); wd.delete();
        send_seq(img_nul, 2);
        chk_status("nul_status", 4'b0010);
        chk("nul_writes", wa.size(), 0);

        // Reset after 1.5 words, then a fresh one-word image
        pulse_start();
        wa.delete(); wd.delete();
        send_seq(part_c, 0);
        chk("mid_writes", wa.size(), 1);
        do_reset(1);
        chk_status("mid_rst", 4'b1000);
        wa.delete(); wd.delete();
        pulse_start();
        send_seq(img_one, 1);
        chk_status("fresh_status", 4'b0010);
        chk("fresh_cnt", wa.size(), 1);
        if (wa.size() == 1) begin
            chk("fresh_a0", wa[0], 32'h0);
            chk("fresh_d0", wd[0], 32'hDEADBEEF);
        end

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
